// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO using all 2^ADDR_W entries, with occupancy
// count, watermark flags, optional first-word-fall-through read and sticky errors.
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4,
  parameter bit FWFT     = 1'b0
) (
  input  logic             clk,
  input  logic             srst,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              empty;
  logic              full;
  logic              wa;
  logic              ra;
  logic              overflow_q;
  logic              underflow_q;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // Extra wrap bit distinguishes full from empty when the addresses coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count = wr_ptr - rd_ptr;

  assign wa = bus.wr_en && !full;
  assign ra = bus.rd_en && !empty;

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_addr] <= bus.din;
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (bus.wr_en && full)  || (overflow_q  && !bus.clr_err);
      underflow_q <= (bus.rd_en && empty) || (underflow_q && !bus.clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.dout  = mem[rd_addr];
      assign bus.valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= ra;
          if (ra) dout_q <= mem[rd_addr];
        end
      end

      assign bus.dout  = dout_q;
      assign bus.valid = valid_q;
    end
  endgenerate

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_TH);
  assign bus.almost_empty = (count <= AE_TH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard-mode instance with a
// reference queue model, plus a directed check of an FWFT instance.
module tb_sync_fifo_param;
  logic clk;
  logic srst;

  sync_fifo_param_if #(.DATA_W(32), .ADDR_W(5)) s_if ();
  sync_fifo_param_if #(.DATA_W(32), .ADDR_W(5)) f_if ();

  sync_fifo_param #(.DATA_W(32), .ADDR_W(5), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b0))
    u_std (.clk(clk), .srst(srst), .bus(s_if.slave));

  sync_fifo_param #(.DATA_W(32), .ADDR_W(5), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b1))
    u_fwft (.clk(clk), .srst(srst), .bus(f_if.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_q [$];
  logic [31:0] exp_q   [$];
  int          mcount  = 0;
  bit          movf    = 0;
  bit          munf    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    logic [5:0] exp_flags;
    exp_flags = {mcount == 0, mcount == 32, mcount >= 28, mcount <= 4, movf, munf};
    check("count", 64'(s_if.count), 64'(mcount));
    check("flags{e,f,af,ae,ovf,unf}",
          64'({s_if.empty, s_if.full, s_if.almost_full, s_if.almost_empty,
               s_if.overflow, s_if.underflow}), 64'(exp_flags));
  endtask

  // One clock on the standard instance; model uses pre-edge state only.
  task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c);
    bit wa, ra;
    s_if.wr_en = w; s_if.din = d; s_if.rd_en = r; s_if.clr_err = c;
    @(posedge clk);
    wa = w && (mcount < 32);
    ra = r && (mcount > 0);
    movf = (w && mcount == 32) || (movf && !c);
    munf = (r && mcount == 0)  || (munf && !c);
    if (ra) begin
      exp_q.push_back(model_q.pop_front());
      mcount--;
    end
    if (wa) begin
      model_q.push_back(d);
      mcount++;
    end
    #1;
    s_if.wr_en = 0; s_if.rd_en = 0; s_if.clr_err = 0;
    check_status();
  endtask

  task automatic fstep(input bit w, input logic [31:0] d, input bit r);
    f_if.wr_en = w; f_if.din = d; f_if.rd_en = r;
    @(posedge clk);
    #1;
    f_if.wr_en = 0; f_if.rd_en = 0;
  endtask

  // Monitor: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (srst) begin
      if (s_if.valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 64'(s_if.valid), 64'd0);
        else check("dout", 64'(s_if.dout), 64'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("missing_valid", 64'(s_if.valid), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 0;
    s_if.wr_en = 0; s_if.din = '0; s_if.rd_en = 0; s_if.clr_err = 0;
    f_if.wr_en = 0; f_if.din = '0; f_if.rd_en = 0; f_if.clr_err = 0;
    repeat (3) @(negedge clk);
    check_status();
    check("reset_dout", 64'(s_if.dout), 64'd0);
    check("reset_valid", 64'(s_if.valid), 64'd0);
    srst = 1;

    // Fill with 0x100..0x11F
    for (int i = 0; i < 32; i++) begin
      step(1, 32'h100 + 32'(i), 0, 0);
      if (i == 26) check("af_below", 64'(s_if.almost_full), 64'd0);
      if (i == 27) check("af_at_28", 64'(s_if.almost_full), 64'd1);
    end
    check("full_after_32", 64'(s_if.full), 64'd1);
    step(1, 32'hDEAD_BEEF, 0, 0);
    check("ovf_33rd", 64'({s_if.overflow, s_if.count}), 64'({1'b1, 6'd32}));

    // Drain
    for (int i = 0; i < 32; i++) step(0, '0, 1, 0);
    check("empty_after_drain", 64'(s_if.empty), 64'd1);
    step(0, '0, 1, 0);
    check("unf_on_empty_read", 64'(s_if.underflow), 64'd1);
    check("dout_hold", 64'(s_if.dout), 64'h11F);
    step(0, '0, 0, 1);
    check("clr_err", 64'({s_if.overflow, s_if.underflow}), 64'd0);

    // Simultaneous at count=10
    for (int i = 0; i < 10; i++) step(1, 32'h200 + 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i), 1, 0);
    check("count_stays_10", 64'(s_if.count), 64'd10);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

    // Simultaneous at full, then clear racing with a new overflow
    for (int i = 0; i < 32; i++) step(1, 32'h400 + 32'(i), 0, 0);
    step(1, 32'h4FF, 1, 0);
    check("full_rw", 64'({s_if.overflow, s_if.count}), 64'({1'b1, 6'd31}));
    step(1, 32'h420, 0, 0);
    step(1, 32'h421, 0, 1);
    check("clr_vs_set", 64'(s_if.overflow), 64'd1);
    step(0, '0, 0, 1);
    check("clr_ovf", 64'(s_if.overflow), 64'd0);
    for (int i = 0; i < 32; i++) step(0, '0, 1, 0);

    // Simultaneous at empty
    step(1, 32'h500, 1, 0);
    check("empty_rw", 64'({s_if.underflow, s_if.count}), 64'({1'b1, 6'd1}));
    step(0, '0, 1, 1);

    // Pointer wrap
    for (int it = 0; it < 100; it++) begin
      for (int i = 0; i < 20; i++) step(1, {16'(it), 16'(i)}, 0, 0);
      for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
    end
    check("wrap_empty", 64'(s_if.empty), 64'd1);

    // Async reset at count=17 with valid and underflow set
    step(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) step(1, 32'h600 + 32'(i), 0, 0);
    step(0, '0, 1, 0);
    check("pre_reset_count", 64'(s_if.count), 64'd17);
    @(negedge clk);
    #2;
    srst = 0;
    #1;
    model_q.delete(); exp_q.delete();
    mcount = 0; movf = 0; munf = 0;
    check_status();
    check("async_rst_valid", 64'(s_if.valid), 64'd0);
    @(negedge clk);
    srst = 1;
    step(1, 32'h777, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // FWFT instance
    fstep(1, 32'hA5A5_A5A5, 0);
    check("fwft_valid", 64'(f_if.valid), 64'd1);
    check("fwft_dout", 64'(f_if.dout), 64'hA5A5_A5A5);
    fstep(0, '0, 1);
    check("fwft_pop", 64'({f_if.valid, f_if.empty}), 64'({1'b0, 1'b1}));
    fstep(1, 32'hB1, 0);
    fstep(1, 32'hB2, 0);
    check("fwft_head", 64'(f_if.dout), 64'hB1);
    fstep(0, '0, 1);
    check("fwft_next", 64'({f_if.valid, f_if.dout}), 64'({1'b1, 32'hB2}));
    fstep(0, '0, 1);
    check("fwft_empty", 64'({f_if.valid, f_if.empty, f_if.count}), 64'({1'b0, 1'b1, 6'd0}));
    fstep(0, '0, 1);
    check("fwft_unf", 64'(f_if.underflow), 64'd1);

    @(negedge clk);
    check("pending_expect", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 32x32 synchronous FIFO.
- Adds configurable width and depth, and uses all 2^ADDR_W entries (no sacrificed slot).
- Adds an occupancy count, almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Sits between bus-side producers (CIM/DMA command and data paths) and consumers that need back-pressure margins.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries.
- AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT=1: pop the head word).
- dout  out  DATA_W  read data.
- valid  out  1  dout holds valid data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (srst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, valid=0, overflow=0, underflow=0.
  - Consequently empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>=1).
  - Memory array is not reset.
- Pointers are ADDR_W+1 bits; bit ADDR_W is the wrap bit. Address = low ADDR_W bits.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1). It may be a separate register but must match this value.
- Write accept (wa) = wr_en & !full. On wa: mem[wr_ptr] <= din, wr_ptr+1.
- Read accept (ra) = rd_en & !empty. On ra: rd_ptr+1.
- Accept decisions use pre-edge flags only:
  - Read and write at full: read accepted, write rejected (overflow set).
  - Read and write at empty: write accepted, read rejected (underflow set).
  - Otherwise, simultaneous wa and ra leave count unchanged.
- Standard mode (FWFT=0):
  - On ra, dout <= mem[rd_ptr] at the same edge; read latency 1 cycle.
  - valid <= ra every cycle (single-cycle pulse per accepted read).
  - dout holds its last value when there is no ra.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr], valid = !empty.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
  - rd_en with valid=1 consumes the word; the next word appears in the same cycle as the pointer update.
  - When empty, dout value is don't-care.
- Error flags:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
  - Both hold until clr_err=1 at a clock edge.
  - If a new error event and clr_err occur in the same cycle, set wins.
- Flags and count are functions of registered state only; no combinational path from wr_en/rd_en to any status output.
- Pointer wrap: 2^(ADDR_W+1) -> 0 rolls over naturally. Full/empty must stay correct across any number of wraps.
- Reset mid-operation: all contents are discarded immediately. First access after srst deasserts behaves as from an empty FIFO.

Test Plan:
- Defaults: reset, then write 32 words 0x100..0x11F.
  - count steps 0..32; almost_full rises when count reaches 28; full=1 after 32nd write.
  - 33rd wr_en -> data dropped, count stays 32, overflow=1.
- Standard mode: drain the full FIFO with rd_en held.
  - dout = 0x100..0x11F, each one cycle after its ra, with a valid pulse.
  - empty=1 after 32 reads; next rd_en -> underflow=1, dout holds 0x11F.
- Simultaneous rd_en+wr_en:
  - At count=10: count stays 10, data order preserved.
  - At full: count 32->31, overflow=1.
  - At empty: count 0->1, underflow=1.
- Wrap: 100 iterations of write 20 / read 20 -> pointers wrap several times; empty/full/count always correct; data matches the scoreboard.
- FWFT=1:
  - Write 0xA5A5A5A5 to empty FIFO -> next cycle valid=1, dout=0xA5A5A5A5 with no rd_en.
  - rd_en -> valid=0, empty=1.
- Error clear and reset:
  - clr_err with overflow=1 and no new error -> overflow=0.
  - clr_err together with wr_en at full -> overflow stays 1.
  - srst pulse low with count=17 -> count=0, empty=1, valid=0, flags=0, asynchronously without a clock edge.
